reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Architectural register file at the far end of the writeback interface.
- Accepts write-enable/destination/data from the write stage and serves two combinational read ports to decode.
- Tracks outstanding destination registers with a pending-write scoreboard; decode uses it to stall on RAW hazards.
- Optional float bank (f0-f31) takes the writeback's float write-enable.

Parameters:
- XLEN, 32, data word width.
- NREGS, 32, registers per bank; address width is log2(NREGS).

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- reg_w_enable  in  1  integer write strobe from writeback.
- freg_w_enable  in  1  float write strobe from writeback (used only with RV32F_EN).
- reg_w_dest  in  5  destination register index.
- reg_w_data  in  XLEN  write data.
- issue_enable  in  1  decode issues an instruction that writes a register.
- issue_is_f  in  1  issued destination is in the float bank.
- issue_dest  in  5  destination of the issued instruction.
- rs1_addr, rs2_addr  in  5 each  read addresses.
- rs1_is_f, rs2_is_f  in  1 each  read from float bank.
- rs1_data, rs2_data  out  XLEN each  read data.
- rs1_busy, rs2_busy  out  1 each  source has a pending write.
- w_ack  out  1  registered one-cycle pulse after any accepted write.
- pending_cnt  out  6  number of pending destinations across both banks.

Behaviour:
- Reset (rstn low, asynchronous):
  - All registers cleared to 0.
  - Pending bits cleared; pending_cnt=0; w_ack=0.
  - Read outputs follow the cleared array, so they read 0.
  - Reset mid-operation discards in-flight pending state.
- Writes: on posedge clk with reg_w_enable=1 and reg_w_dest!=0, the integer register is updated.
  - A write to x0 is ignored, but it still clears nothing and still pulses w_ack.
- Reads: combinational with write-first bypass.
  - If the matching bank's w_enable is set, reg_w_dest==rs_addr, and (float bank or rs_addr!=0), rs_data=reg_w_data.
  - Otherwise rs_data is the array contents.
  - Integer address 0 always reads 0.
- Scoreboard: one pending bit per register per bank.
  - Set on posedge when issue_enable=1. Integer issue_dest=0 never sets.
  - Cleared on posedge by the matching bank's write to that index.
  - Same-cycle issue and write to the same register: the set wins (the newer producer stays outstanding). pending_cnt is unchanged in that case.
  - Issue to an already-pending register: the bit stays set and the count does not increment.
  - Write to a non-pending register: the data is still written and the count does not decrement.
- Busy: rs_busy = pending[bank][rs_addr] && !(same-cycle clearing write to that register and bank).
  - A hazard resolves in the same cycle as its writeback, consistent with the bypass.
- pending_cnt: population count, maintained incrementally as +set_new -clear_hit.
  - Saturates are impossible by construction (max 63).
- w_ack: registered; equals 1 in the cycle after any reg_w_enable or freg_w_enable, otherwise 0.
- Simultaneous reg_w_enable and freg_w_enable: both banks are written at the same index.
  - This is illegal from the writeback but defined here.

Optional Feature:
- Macro RV32F_EN.
- Defined:
  - Float bank of NREGS x XLEN with its own pending bits.
  - f0 is writable.
  - freg_w_enable, issue_is_f and rs*_is_f are honoured.
- Undefined:
  - No float storage.
  - *_is_f reads return 0 with busy 0.
  - freg_w_enable and float issues are ignored (no pending bit set, count unchanged).
  - w_ack still pulses on freg_w_enable.

Decomposition:
- Shared package (core-wide): XLEN, register address width, typedefs reg_addr_t and word_t.
- Sub-module reg_scoreboard: pending bits, busy lookup, pending_cnt. Instantiated once per bank, counts summed in the top.
- Storage and bypass stay in reg_file_sb.

Test Plan:
- Reset, then read x0..x31 -> all 0; pending_cnt=0; w_ack=0.
- Write x5=0xDEADBEEF with rs1_addr=5 in the same cycle -> rs1_data=0xDEADBEEF (bypass). Next cycle from the array still 0xDEADBEEF; w_ack=1 for one cycle.
- Write x0=0x12345678 -> rs1_addr=0 reads 0 in both the same and the following cycle.
- Issue x7; next cycle rs2_addr=7 -> rs2_busy=1, pending_cnt=1. Write x7=0x42 -> same cycle rs2_busy=0, rs2_data=0x42; next cycle pending_cnt=0.
- Issue x9 and write x9 in the same cycle (x9 previously pending) -> x9 stays pending, pending_cnt unchanged, data updated.
- With RV32F_EN: write f0=0x3F800000, read rs1_is_f=1, rs1_addr=0 -> 0x3F800000. Without RV32F_EN -> 0 and busy 0.
- Assert rstn low mid-stream with 3 pending -> pending_cnt=0 immediately (asynchronous), all busy flags 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Core-wide types shared by the register file and its scoreboards:
// data word width, register address width and the matching typedefs.
package reg_file_sb_pkg;

    localparam int CORE_XLEN = 32;
    localparam int REG_AW    = 5;

    typedef logic [REG_AW-1:0]    reg_addr_t;
    typedef logic [CORE_XLEN-1:0] word_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard for one register bank: one bit per register,
// busy lookup for two read ports and an incrementally maintained count.
module reg_scoreboard
    import reg_file_sb_pkg::*;
#(
    parameter int NREGS   = 32,
    parameter bit ZERO_HW = 1'b1
) (
    input  logic      clk,
    input  logic      rstn,
    input  logic      issue_set,
    input  reg_addr_t issue_dest,
    input  logic      clr,
    input  reg_addr_t clr_dest,
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    output logic      rs1_busy,
    output logic      rs2_busy,
    output logic [5:0] cnt
);

    logic pending [NREGS];
    logic set_eff;
    logic set_new;
    logic clear_hit;

    // A same-cycle issue to the register being written keeps it outstanding.
    assign set_eff   = issue_set && !(ZERO_HW && issue_dest == '0);
    assign set_new   = set_eff && !pending[issue_dest];
    assign clear_hit = clr && pending[clr_dest] && !(set_eff && issue_dest == clr_dest);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_pending
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    pending[gi] <= 1'b0;
                end else if (set_eff && issue_dest == reg_addr_t'(gi)) begin
                    pending[gi] <= 1'b1;
                end else if (clr && clr_dest == reg_addr_t'(gi)) begin
                    pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 6'(set_new) - 6'(clear_hit);
        end
    end

    assign rs1_busy = pending[rs1_addr] && !(clr && clr_dest == rs1_addr);
    assign rs2_busy = pending[rs2_addr] && !(clr && clr_dest == rs2_addr);

endmodule

// File: rtl/reg_file_sb.sv
// Architectural register file with write-first bypass and pending-write
// scoreboard. Optional float bank f0-f31 enabled by macro RV32F_EN.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN  = CORE_XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            reg_w_enable,
    input  logic            freg_w_enable,
    input  reg_addr_t       reg_w_dest,
    input  logic [XLEN-1:0] reg_w_data,
    input  logic            issue_enable,
    input  logic            issue_is_f,
    input  reg_addr_t       issue_dest,
    input  reg_addr_t       rs1_addr,
    input  reg_addr_t       rs2_addr,
    input  logic            rs1_is_f,
    input  logic            rs2_is_f,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            w_ack,
    output logic [5:0]      pending_cnt
);

    logic [XLEN-1:0] xregs [NREGS];
    logic [XLEN-1:0] x_rd1, x_rd2, f_rd1, f_rd2;
    logic            x_busy1, x_busy2, f_busy1, f_busy2;
    logic [5:0]      x_cnt, f_cnt;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_xregs
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    xregs[gi] <= '0;
                end else if (reg_w_enable && reg_w_dest != '0 && reg_w_dest == reg_addr_t'(gi)) begin
                    xregs[gi] <= reg_w_data;
                end
            end
        end
    endgenerate

    always_comb begin
        x_rd1 = '0;
        x_rd2 = '0;
        if (rs1_addr != '0) begin
            x_rd1 = (reg_w_enable && reg_w_dest == rs1_addr) ? reg_w_data : xregs[rs1_addr];
        end
        if (rs2_addr != '0) begin
            x_rd2 = (reg_w_enable && reg_w_dest == rs2_addr) ? reg_w_data : xregs[rs2_addr];
        end
    end

    reg_scoreboard #(.NREGS(NREGS), .ZERO_HW(1'b1)) u_x_sb (
        .clk       (clk),
        .rstn      (rstn),
        .issue_set (issue_enable && !issue_is_f),
        .issue_dest(issue_dest),
        .clr       (reg_w_enable),
        .clr_dest  (reg_w_dest),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (x_busy1),
        .rs2_busy  (x_busy2),
        .cnt       (x_cnt)
    );

`ifdef RV32F_EN
    logic [XLEN-1:0] fregs [NREGS];

    for (gi = 0; gi < NREGS; gi++) begin : g_fregs
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                fregs[gi] <= '0;
            end else if (freg_w_enable && reg_w_dest == reg_addr_t'(gi)) begin
                fregs[gi] <= reg_w_data;
            end
        end
    end

    // f0 is an ordinary register, so the bypass has no zero exception.
    assign f_rd1 = (freg_w_enable && reg_w_dest == rs1_addr) ? reg_w_data : fregs[rs1_addr];
    assign f_rd2 = (freg_w_enable && reg_w_dest == rs2_addr) ? reg_w_data : fregs[rs2_addr];

    reg_scoreboard #(.NREGS(NREGS), .ZERO_HW(1'b0)) u_f_sb (
        .clk       (clk),
        .rstn      (rstn),
        .issue_set (issue_enable && issue_is_f),
        .issue_dest(issue_dest),
        .clr       (freg_w_enable),
        .clr_dest  (reg_w_dest),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (f_busy1),
        .rs2_busy  (f_busy2),
        .cnt       (f_cnt)
    );
`else
    assign f_rd1   = '0;
    assign f_rd2   = '0;
    assign f_busy1 = 1'b0;
    assign f_busy2 = 1'b0;
    assign f_cnt   = '0;
`endif

    assign rs1_data    = rs1_is_f ? f_rd1   : x_rd1;
    assign rs2_data    = rs2_is_f ? f_rd2   : x_rd2;
    assign rs1_busy    = rs1_is_f ? f_busy1 : x_busy1;
    assign rs2_busy    = rs2_is_f ? f_busy2 : x_busy2;
    assign pending_cnt = x_cnt + f_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_ack <= 1'b0;
        end else begin
            w_ack <= reg_w_enable || freg_w_enable;
        end
    end

endmodule
